// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared types and helpers for the ctrl_chain_sync handshake chain.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int c_MAX_STAGES = 64;
    localparam int c_REQ_BIT    = 1;
    localparam int c_NACK_BIT   = 0;

    // Packed stage inputs {req, nack}
    typedef logic [1:0] cstage_in_t;

    // Stage i holds a token when its state differs from its successor
    // (the next stage, or the synchronised ack for the last stage).
    function automatic int count_tokens(input logic [c_MAX_STAGES-1:0] state,
                                        input logic [c_MAX_STAGES-1:0] succ);
        int cnt;
        cnt = 0;
        for (int i = 0; i < c_MAX_STAGES; i++) begin
            cnt += int'(state[i] ^ succ[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_cstage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_cstage
// Purpose  : One clocked C-element control stage with a one-cycle fire pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_cstage
    import ctrl_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic c,
    output logic fire
);

    cstage_in_t w_in;
    logic       r_c_q;

    assign w_in = {req, ~ack};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c     <= RST_VAL;
            r_c_q <= RST_VAL;
        end else begin
            if (w_in[c_REQ_BIT] == w_in[c_NACK_BIT]) begin
                c <= w_in[c_REQ_BIT];
            end
            r_c_q <= c;
        end
    end

    assign fire = c ^ r_c_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_chain_sync.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_chain_sync
// Purpose  : Clocked chain of two-phase C-element control stages with optional
//            input synchronisers; CTRL_CHAIN_STATS_EN adds xfer_cnt and stall.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_chain_sync
    import ctrl_pkg::*;
#(
    parameter int                STAGES      = 4,
    parameter logic [STAGES-1:0] RST_MASK    = '0,
    parameter int                SYNC_STAGES = 2,
    parameter int                CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    input  logic                         ack_out,
    output logic                         req_out,
    output logic                         ack_in,
    output logic [STAGES-1:0]            ctrl_out,
    output logic [STAGES-1:0]            ctrl_fire,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef CTRL_CHAIN_STATS_EN
    ,
    output logic [CNT_W-1:0]             xfer_cnt,
    output logic                         stall
`endif
);

    localparam int c_OCC_W = $clog2(STAGES+1);
    // Sync flops reset to 0, so the reset-time successor of the last stage is 0
    localparam logic [c_OCC_W-1:0] c_RST_OCC =
        c_OCC_W'(count_tokens(c_MAX_STAGES'(RST_MASK), c_MAX_STAGES'(RST_MASK >> 1)));

    logic               w_req_s;
    logic               w_ack_s;
    logic [STAGES-1:0]  w_c;
    logic [STAGES-1:0]  w_fire;
    logic [STAGES-1:0]  w_prev;
    logic [STAGES-1:0]  w_succ;
    logic [c_OCC_W-1:0] r_occupancy;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_req_sync;
            logic [SYNC_STAGES-1:0] r_ack_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_req_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync[0] <= req_in;
                    r_ack_sync[0] <= ack_out;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_req_sync[k] <= r_req_sync[k-1];
                        r_ack_sync[k] <= r_ack_sync[k-1];
                    end
                end
            end

            assign w_req_s = r_req_sync[SYNC_STAGES-1];
            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_req_s = req_in;
            assign w_ack_s = ack_out;
        end
    endgenerate

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_prev[i] = w_req_s;
        end else begin : g_body
            assign w_prev[i] = w_c[i-1];
        end

        if (i == STAGES-1) begin : g_tail
            assign w_succ[i] = w_ack_s;
        end else begin : g_link
            assign w_succ[i] = w_c[i+1];
        end

        ctrl_cstage #(
            .RST_VAL (RST_MASK[i])
        ) u_cstage (
            .clk  (clk),
            .rst  (rst),
            .req  (w_prev[i]),
            .ack  (w_succ[i]),
            .c    (w_c[i]),
            .fire (w_fire[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupancy <= c_RST_OCC;
        end else begin
            r_occupancy <= c_OCC_W'(count_tokens(c_MAX_STAGES'(w_c), c_MAX_STAGES'(w_succ)));
        end
    end

    assign req_out   = w_c[STAGES-1];
    assign ack_in    = w_c[0];
    assign ctrl_out  = w_c;
    assign ctrl_fire = w_fire;
    assign occupancy = r_occupancy;

`ifdef CTRL_CHAIN_STATS_EN
    logic [CNT_W-1:0] r_xfer_cnt;
    logic             r_stall;

    // The last stage's fire pulse marks each req_out toggle exactly once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            if (w_fire[STAGES-1]) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
            r_stall <= w_c[STAGES-1] ^ w_ack_s;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
    assign stall    = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_chain_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_chain_sync
// Purpose  : Directed-vector bench for ctrl_chain_sync (three configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_chain_sync;

    logic clk = 1'b0;
    logic rst;

    logic       req0, ack0, req_out0, ack_in0;
    logic [3:0] ctrl0, fire0;
    logic [2:0] occ0;
    logic       req1, ack1, req_out1, ack_in1;
    logic [3:0] ctrl1, fire1;
    logic [2:0] occ1;
    logic       req2, ack2, req_out2, ack_in2;
    logic [3:0] ctrl2, fire2;
    logic [2:0] occ2;
`ifdef CTRL_CHAIN_STATS_EN
    logic [1:0]  xfer0;
    logic [15:0] xfer1, xfer2;
    logic        stall0, stall1, stall2;
`endif

    always #5 clk = ~clk;

    ctrl_chain_sync #(.STAGES(4), .RST_MASK(4'b0000), .SYNC_STAGES(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_in(req0), .ack_out(ack0), .req_out(req_out0),
        .ack_in(ack_in0), .ctrl_out(ctrl0), .ctrl_fire(fire0), .occupancy(occ0)
`ifdef CTRL_CHAIN_STATS_EN
        , .xfer_cnt(xfer0), .stall(stall0)
`endif
    );

    ctrl_chain_sync #(.STAGES(4), .RST_MASK(4'b1000), .SYNC_STAGES(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .req_in(req1), .ack_out(ack1), .req_out(req_out1),
        .ack_in(ack_in1), .ctrl_out(ctrl1), .ctrl_fire(fire1), .occupancy(occ1)
`ifdef CTRL_CHAIN_STATS_EN
        , .xfer_cnt(xfer1), .stall(stall1)
`endif
    );

    ctrl_chain_sync #(.STAGES(4), .RST_MASK(4'b0000), .SYNC_STAGES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .req_in(req2), .ack_out(ack2), .req_out(req_out2),
        .ack_in(ack_in2), .ctrl_out(ctrl2), .ctrl_fire(fire2), .occupancy(occ2)
`ifdef CTRL_CHAIN_STATS_EN
        , .xfer_cnt(xfer2), .stall(stall2)
`endif
    );

    typedef struct {
        logic       req;
        logic       ack;
        logic [3:0] ctrl;
        logic [3:0] fire;
        logic [2:0] occ;
    } vec_t;

    vec_t vecs [18];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; ack0 = 1'b0;
        req1 = 1'b0; ack1 = 1'b0;
        req2 = 1'b0; ack2 = 1'b0;

        // Fill, full stall, then one token drained (expected state after each edge)
        vecs[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0011, 4'b0010, 3'd1};
        vecs[2]  = '{1'b1, 1'b0, 4'b0111, 4'b0100, 3'd1};
        vecs[3]  = '{1'b1, 1'b0, 4'b1111, 4'b1000, 3'd1};
        vecs[4]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, 4'b1110, 4'b0001, 3'd1};
        vecs[6]  = '{1'b0, 1'b0, 4'b1100, 4'b0010, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 4'b1000, 4'b0100, 3'd2};
        vecs[8]  = '{1'b1, 1'b0, 4'b1001, 4'b0001, 3'd2};
        vecs[9]  = '{1'b1, 1'b0, 4'b1011, 4'b0010, 3'd3};
        vecs[10] = '{1'b0, 1'b0, 4'b1010, 4'b0001, 3'd3};
        vecs[11] = '{1'b0, 1'b0, 4'b1010, 4'b0000, 3'd4};
        vecs[12] = '{1'b1, 1'b0, 4'b1010, 4'b0000, 3'd4};
        vecs[13] = '{1'b1, 1'b1, 4'b0010, 4'b1000, 3'd3};
        vecs[14] = '{1'b1, 1'b1, 4'b0110, 4'b0100, 3'd3};
        vecs[15] = '{1'b1, 1'b1, 4'b0100, 4'b0010, 3'd3};
        vecs[16] = '{1'b1, 1'b1, 4'b0101, 4'b0001, 3'd3};
        vecs[17] = '{1'b1, 1'b1, 4'b0101, 4'b0000, 3'd4};

        #12 rst = 1'b0;
        tick();

        check("rst0.ctrl", 32'(ctrl0), 32'd0);
        check("rst0.fire", 32'(fire0), 32'd0);
        check("rst0.req_out", 32'(req_out0), 32'd0);
        check("rst0.ack_in", 32'(ack_in0), 32'd0);
        check("rst0.occ", 32'(occ0), 32'd0);

        // Mask 1000: stage 2 differs from stage 3, stage 3 differs from ack -> two tokens
        check("rst1.ctrl", 32'(ctrl1), 32'(4'b1000));
        check("rst1.req_out", 32'(req_out1), 32'd1);
        check("rst1.ack_in", 32'(ack_in1), 32'd0);
        check("rst1.occ", 32'(occ1), 32'd2);
        ack1 = 1'b1;
        tick();
        check("tok1.ctrl", 32'(ctrl1), 32'd0);
        check("tok1.fire", 32'(fire1), 32'(4'b1000));
        check("tok1.req_out", 32'(req_out1), 32'd0);
        check("tok1.occ", 32'(occ1), 32'd1);
        tick();
        check("tok1.occ_settled", 32'(occ1), 32'd1);
        check("tok1.fire_clear", 32'(fire1), 32'd0);

        // Two synchroniser flops: ack_in after 3 edges, req_out after 6
        req2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) check("lat2.ack_in_early", 32'(ack_in2), 32'd0);
            if (k == 3) check("lat2.ack_in", 32'(ack_in2), 32'd1);
            if (k == 5) check("lat2.req_out_early", 32'(req_out2), 32'd0);
            if (k == 6) check("lat2.req_out", 32'(req_out2), 32'd1);
        end

        for (int i = 0; i < 18; i++) begin
            req0 = vecs[i].req;
            ack0 = vecs[i].ack;
            tick();
            check($sformatf("vec%0d.ctrl", i), 32'(ctrl0), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d.fire", i), 32'(fire0), 32'(vecs[i].fire));
            check($sformatf("vec%0d.occ", i), 32'(occ0), 32'(vecs[i].occ));
            check($sformatf("vec%0d.req_out", i), 32'(req_out0), 32'(vecs[i].ctrl[3]));
            check($sformatf("vec%0d.ack_in", i), 32'(ack_in0), 32'(vecs[i].ctrl[0]));
        end

        // Reset mid-flight with two tokens in the chain
        req0 = 1'b0; ack0 = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            req0 = vecs[i].req;
            ack0 = vecs[i].ack;
            tick();
        end
        check("mid.occ_before", 32'(occ0), 32'd2);
        check("mid.fire_before", 32'(fire0), 32'(4'b0010));
        #2 rst = 1'b1;
        #1;
        check("mid.ctrl", 32'(ctrl0), 32'd0);
        check("mid.fire", 32'(fire0), 32'd0);
        check("mid.occ", 32'(occ0), 32'd0);
        check("mid.req_out", 32'(req_out0), 32'd0);
        req0 = 1'b0; ack0 = 1'b0;
        #1 rst = 1'b0;
        tick();
        check("mid.ctrl_after", 32'(ctrl0), 32'd0);

`ifdef CTRL_CHAIN_STATS_EN
        check("stats.xfer_rst", 32'(xfer0), 32'd0);
        check("stats.stall_rst", 32'(stall0), 32'd0);
        for (int t = 0; t < 5; t++) begin
            int waited;
            waited = 0;
            req0 = ~req0;
            while (req_out0 !== req0 && waited < 20) begin
                tick();
                waited++;
            end
            check($sformatf("stats.req_out%0d", t), 32'(req_out0), 32'(req0));
            tick();
            tick();
            if (t == 0) check("stats.stall_full", 32'(stall0), 32'd1);
            ack0 = req0;
            repeat (3) tick();
            if (t == 0) check("stats.stall_clear", 32'(stall0), 32'd0);
        end
        check("stats.xfer_wrap", 32'(xfer0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
